// File: rtl/pcpu_ctrl_pkg.sv
// Control encodings shared by the pcpu hazard controller and the forwarding unit.
// Pure declarations: no logic, no latency, no flow control.
package pcpu_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    HALT     = 2'b10
  } hz_state_t;

  localparam int MEM_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_t;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Wrap-around event counter: clear wins over increment, both take effect on the next edge.
// Never stalls anything; counts whatever inc reports.
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr)      cnt <= '0;
    else if (inc) cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline advance/hold/flush decisions for the 5-stage pcpu; enables are combinational (0 cycles).
// Data-memory waits freeze the whole pipe and a stuck memory halts the core until rst.
module hazard_ctrl
  import pcpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_use_rs1,
  input  logic             ID_use_rs2,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_rd,
  input  logic             EX_redirect,
  input  logic             MEM_req,
  input  logic             MEM_ready,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_write,
  output logic             ID_EX_flush,
  output logic             EX_MEM_write,
  output logic             MEM_WB_flush,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  hz_state_t         state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              lu, mw, freeze, resolve, redirect_apply;

  assign lu = EX_MemRead && (EX_rd != 5'd0) &&
              ((ID_use_rs1 && (ID_rs1 == EX_rd)) || (ID_use_rs2 && (ID_rs2 == EX_rd)));
  assign mw = MEM_req && !MEM_ready;

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    freeze         = 1'b0;
    resolve        = 1'b0;
    redirect_apply = 1'b0;
    mem_timeout    = 1'b0;
    PC_write       = 1'b1;
    IF_ID_write    = 1'b1;
    ID_EX_write    = 1'b1;
    EX_MEM_write   = 1'b1;
    IF_ID_flush    = 1'b0;
    ID_EX_flush    = 1'b0;
    MEM_WB_flush   = 1'b0;

    // wait_cnt holds the not-ready cycles already seen, so the entry cycle counts as the first.
    case (state_q)
      RUN: begin
        if (mw) begin
          freeze     = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end else begin
          resolve = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!MEM_ready) begin
          freeze = 1'b1;
          if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
            mem_timeout = 1'b1;
            state_d     = HALT;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end else begin
          state_d = RUN;
          resolve = 1'b1;
        end
      end
      HALT: begin
        PC_write     = 1'b0;
        IF_ID_write  = 1'b0;
        ID_EX_write  = 1'b0;
        EX_MEM_write = 1'b0;
      end
      default: state_d = RUN;
    endcase

    if (freeze) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_write  = 1'b0;
      EX_MEM_write = 1'b0;
      MEM_WB_flush = 1'b1;
    end

    // A redirect squashes the load-use victim, so it takes precedence over the bubble.
    if (resolve) begin
      if (EX_redirect) begin
        IF_ID_flush    = 1'b1;
        ID_EX_flush    = 1'b1;
        redirect_apply = 1'b1;
      end else if (lu) begin
        PC_write    = 1'b0;
        IF_ID_write = 1'b0;
        ID_EX_flush = 1'b1;
      end
    end

    if (rst) begin
      PC_write       = 1'b0;
      IF_ID_write    = 1'b0;
      ID_EX_write    = 1'b0;
      EX_MEM_write   = 1'b0;
      IF_ID_flush    = 1'b1;
      ID_EX_flush    = 1'b1;
      MEM_WB_flush   = 1'b1;
      mem_timeout    = 1'b0;
      redirect_apply = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign halted = (state_q == HALT) && !rst;

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .inc (!PC_write && (state_q != HALT)),
    .cnt (stall_cnt)
  );

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .clr (rst),
    .inc (redirect_apply),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a short memory timeout.
module tb_hazard_ctrl;

  localparam int CNT_W = 32;

  // {PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, IF_ID_flush, ID_EX_flush, MEM_WB_flush}
  localparam logic [6:0] O_NORM  = 7'b1111_000;
  localparam logic [6:0] O_FRZ   = 7'b0000_001;
  localparam logic [6:0] O_LU    = 7'b0011_010;
  localparam logic [6:0] O_REDIR = 7'b1111_110;
  localparam logic [6:0] O_RST   = 7'b0000_111;
  localparam logic [6:0] O_HALT  = 7'b0000_000;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       ID_rs1, ID_rs2, EX_rd;
  logic             ID_use_rs1, ID_use_rs2, EX_MemRead, EX_redirect, MEM_req, MEM_ready;
  logic             PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush;
  logic             EX_MEM_write, MEM_WB_flush, halted, mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .ID_rs1       (ID_rs1),
    .ID_rs2       (ID_rs2),
    .ID_use_rs1   (ID_use_rs1),
    .ID_use_rs2   (ID_use_rs2),
    .EX_MemRead   (EX_MemRead),
    .EX_rd        (EX_rd),
    .EX_redirect  (EX_redirect),
    .MEM_req      (MEM_req),
    .MEM_ready    (MEM_ready),
    .PC_write     (PC_write),
    .IF_ID_write  (IF_ID_write),
    .IF_ID_flush  (IF_ID_flush),
    .ID_EX_write  (ID_EX_write),
    .ID_EX_flush  (ID_EX_flush),
    .EX_MEM_write (EX_MEM_write),
    .MEM_WB_flush (MEM_WB_flush),
    .halted       (halted),
    .mem_timeout  (mem_timeout),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  function automatic logic [6:0] outs();
    return {PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, IF_ID_flush, ID_EX_flush, MEM_WB_flush};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ID_rs1 = 5'd0; ID_rs2 = 5'd0; EX_rd = 5'd0;
    ID_use_rs1 = 1'b0; ID_use_rs2 = 1'b0; EX_MemRead = 1'b0;
    EX_redirect = 1'b0; MEM_req = 1'b0; MEM_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    #1;
    chk("rst_outs", 32'(outs()), 32'(O_RST));
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_timeout", 32'(mem_timeout), 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_flush_cnt", flush_cnt, 32'd0);

    rst = 1'b0;
    #1 chk("idle_normal", 32'(outs()), 32'(O_NORM));
    tick();

    // Load-use through rs2
    EX_MemRead = 1'b1; EX_rd = 5'd5; ID_rs2 = 5'd5; ID_use_rs2 = 1'b1;
    #1 chk("lu_outs", 32'(outs()), 32'(O_LU));
    chk("lu_stall_before", stall_cnt, 32'd0);
    tick();
    idle_inputs();
    #1 chk("lu_after_outs", 32'(outs()), 32'(O_NORM));
    chk("lu_stall_after", stall_cnt, 32'd1);

    // Load to x0 never stalls
    EX_MemRead = 1'b1; EX_rd = 5'd0; ID_rs2 = 5'd0; ID_use_rs2 = 1'b1;
    #1 chk("lu_x0_outs", 32'(outs()), 32'(O_NORM));
    tick();
    chk("lu_x0_stall", stall_cnt, 32'd1);

    // Matching rs1 that is not read
    EX_MemRead = 1'b1; EX_rd = 5'd7; ID_rs1 = 5'd7; ID_use_rs1 = 1'b0; ID_use_rs2 = 1'b0;
    #1 chk("lu_unused_rs1", 32'(outs()), 32'(O_NORM));
    // Redirect outranks a real load-use on rs1
    ID_use_rs1 = 1'b1; EX_redirect = 1'b1;
    #1 chk("redir_over_lu", 32'(outs()), 32'(O_REDIR));
    tick();
    idle_inputs();
    #1 chk("redir_flush_cnt", flush_cnt, 32'd1);
    chk("redir_stall_cnt", stall_cnt, 32'd1);

    // Memory wait: 3 not-ready cycles, then ready
    MEM_req = 1'b1; MEM_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("mw_frz_%0d", i), 32'(outs()), 32'(O_FRZ));
      tick();
    end
    MEM_ready = 1'b1;
    #1 chk("mw_release", 32'(outs()), 32'(O_NORM));
    chk("mw_no_timeout", 32'(mem_timeout), 32'd0);
    tick();
    chk("mw_stall_cnt", stall_cnt, 32'd4);
    // Ready in the same cycle as the request: no wait
    #1 chk("mw_ready_now", 32'(outs()), 32'(O_NORM));
    tick();
    idle_inputs();

    // Redirect held through a 2-cycle wait
    MEM_req = 1'b1; MEM_ready = 1'b0; EX_redirect = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1 chk($sformatf("rw_frz_%0d", i), 32'(outs()), 32'(O_FRZ));
      tick();
    end
    MEM_ready = 1'b1;
    #1 chk("rw_release", 32'(outs()), 32'(O_REDIR));
    tick();
    idle_inputs();
    #1 chk("rw_flush_cnt", flush_cnt, 32'd2);
    chk("rw_stall_cnt", stall_cnt, 32'd6);

    // Reset in wait cycle 2
    MEM_req = 1'b1; MEM_ready = 1'b0;
    #1 chk("rmw_frz", 32'(outs()), 32'(O_FRZ));
    tick();
    rst = 1'b1;
    #1 chk("rmw_rst_outs", 32'(outs()), 32'(O_RST));
    chk("rmw_rst_timeout", 32'(mem_timeout), 32'd0);
    tick();
    rst = 1'b0;
    #1 chk("rmw_run_outs", 32'(outs()), 32'(O_FRZ));
    chk("rmw_stall_cnt", stall_cnt, 32'd0);
    chk("rmw_flush_cnt", flush_cnt, 32'd0);
    MEM_req = 1'b0;
    #1 chk("rmw_run_idle", 32'(outs()), 32'(O_NORM));
    tick();
    chk("rmw_stall_cnt2", stall_cnt, 32'd0);

    // Timeout after 4 not-ready cycles
    MEM_req = 1'b1; MEM_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("to_frz_%0d", i), 32'(outs()), 32'(O_FRZ));
      chk($sformatf("to_quiet_%0d", i), 32'(mem_timeout), 32'd0);
      tick();
    end
    #1 chk("to_pulse", 32'(mem_timeout), 32'd1);
    chk("to_pulse_outs", 32'(outs()), 32'(O_FRZ));
    chk("to_not_halted_yet", 32'(halted), 32'd0);
    tick();
    chk("to_halted", 32'(halted), 32'd1);
    chk("to_pulse_gone", 32'(mem_timeout), 32'd0);
    chk("to_halt_outs", 32'(outs()), 32'(O_HALT));
    chk("to_stall_cnt", stall_cnt, 32'd4);
    MEM_ready = 1'b1; EX_redirect = 1'b1;
    #1 chk("halt_ignores_in", 32'(outs()), 32'(O_HALT));
    tick();
    chk("halt_sticky", 32'(halted), 32'd1);
    chk("halt_stall_frozen", stall_cnt, 32'd4);
    chk("halt_flush_frozen", flush_cnt, 32'd0);

    // Reset leaves HALT
    rst = 1'b1;
    #1 chk("halt_rst_halted", 32'(halted), 32'd0);
    tick();
    rst = 1'b0;
    idle_inputs();
    #1 chk("post_halt_outs", 32'(outs()), 32'(O_NORM));
    chk("post_halt_halted", 32'(halted), 32'd0);
    chk("post_halt_stall", stall_cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
